// File: rtl/traffic_pkg.sv
// Shared junction definitions: phase encodings, lamp patterns and the
// state-to-lamp decode used by the sequencer and future display blocks.
package traffic_pkg;

    localparam int SECS_W = 6;

    typedef enum logic [2:0] {
        ST_ALLRED_A  = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_ALLRED_B  = 3'd3,
        ST_EW_GREEN  = 3'd4,
        ST_EW_YELLOW = 3'd5,
        ST_WALK      = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l = '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
        case (s)
            ST_NS_GREEN:  l.ns   = LAMP_GRN;
            ST_NS_YELLOW: l.ns   = LAMP_YEL;
            ST_EW_GREEN:  l.ew   = LAMP_GRN;
            ST_EW_YELLOW: l.ew   = LAMP_YEL;
            ST_WALK:      l.walk = 1'b1;
            default:      l      = '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/light_sequencer_if.sv
// Sequencer-facing signal bundle: divider/button inputs and lamp/display outputs.
interface light_sequencer_if;
    import traffic_pkg::*;

    logic              enable;
    logic              ped_req;
    logic [2:0]        ns_light;
    logic [2:0]        ew_light;
    logic              walk;
    logic              ped_ack;
    logic [SECS_W-1:0] secs_left;

    modport master (
        output enable, ped_req,
        input  ns_light, ew_light, walk, ped_ack, secs_left
    );

    modport slave (
        input  enable, ped_req,
        output ns_light, ew_light, walk, ped_ack, secs_left
    );

endinterface

// File: rtl/tick_edge_detect.sv
// One-cycle tick on each rising edge of the 1 Hz enable square wave.
module tick_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    logic r_en_d;

    // Resets high so an enable already high at reset release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_en_d <= 1'b1;
        else          r_en_d <= enable;
    end

    assign tick = enable & ~r_en_d;

endmodule

// File: rtl/light_sequencer.sv
// Junction phase FSM: per-phase seconds timer, pedestrian latch and
// registered lamp/display outputs, advanced once per enable rising edge.
module light_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_SECS  = 10,
    parameter int YELLOW_SECS = 3,
    parameter int ALLRED_SECS = 1,
    parameter int WALK_SECS   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    light_sequencer_if.slave  bus
);

    localparam int SECS_MAX = (1 << SECS_W) - 1;

    if (GREEN_SECS < 1 || GREEN_SECS > SECS_MAX || YELLOW_SECS < 1 || YELLOW_SECS > SECS_MAX ||
        ALLRED_SECS < 1 || ALLRED_SECS > SECS_MAX || WALK_SECS < 1 || WALK_SECS > SECS_MAX) begin : g_param_err
        $error("light_sequencer: phase durations must be in 1..63");
    end

    logic              w_tick;
    state_t            r_state, w_state_next;
    logic [SECS_W-1:0] r_secs, w_secs_next;
    logic              r_pending, w_pending_next;
    logic              r_resume_ew, w_resume_next;
    logic              w_walk_entry;
    logic              r_ped_ack;
    lamps_t            r_lamps, w_lamps_next;

    tick_edge_detect u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (bus.enable),
        .tick    (w_tick)
    );

    function automatic logic [SECS_W-1:0] phase_secs(input state_t s);
        case (s)
            ST_NS_GREEN, ST_EW_GREEN:   return SECS_W'(GREEN_SECS);
            ST_NS_YELLOW, ST_EW_YELLOW: return SECS_W'(YELLOW_SECS);
            ST_WALK:                    return SECS_W'(WALK_SECS);
            default:                    return SECS_W'(ALLRED_SECS);
        endcase
    endfunction

    always_comb begin
        w_state_next  = r_state;
        w_secs_next   = r_secs;
        w_resume_next = r_resume_ew;
        w_walk_entry  = 1'b0;
        if (w_tick) begin
            if (r_secs > 6'd1) begin
                w_secs_next = r_secs - 1'b1;
            end else begin
                // resume_ew remembers which green the interrupted all-red would have led to
                case (r_state)
                    ST_ALLRED_A: begin
                        if (r_pending) begin
                            w_state_next  = ST_WALK;
                            w_walk_entry  = 1'b1;
                            w_resume_next = 1'b0;
                        end else begin
                            w_state_next  = ST_NS_GREEN;
                        end
                    end
                    ST_NS_GREEN:  w_state_next = ST_NS_YELLOW;
                    ST_NS_YELLOW: w_state_next = ST_ALLRED_B;
                    ST_ALLRED_B: begin
                        if (r_pending) begin
                            w_state_next  = ST_WALK;
                            w_walk_entry  = 1'b1;
                            w_resume_next = 1'b1;
                        end else begin
                            w_state_next  = ST_EW_GREEN;
                        end
                    end
                    ST_EW_GREEN:  w_state_next = ST_EW_YELLOW;
                    ST_EW_YELLOW: w_state_next = ST_ALLRED_A;
                    ST_WALK:      w_state_next = r_resume_ew ? ST_EW_GREEN : ST_NS_GREEN;
                    default:      w_state_next = ST_ALLRED_A;
                endcase
                w_secs_next = phase_secs(w_state_next);
            end
        end
        // A press coinciding with WALK entry survives the clear and is served next time.
        w_pending_next = (r_pending & ~w_walk_entry) | bus.ped_req;
        w_lamps_next   = decode_lamps(w_state_next);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ALLRED_A;
            r_secs      <= SECS_W'(ALLRED_SECS);
            r_pending   <= 1'b0;
            r_resume_ew <= 1'b0;
            r_ped_ack   <= 1'b0;
            r_lamps     <= '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
        end else begin
            r_state     <= w_state_next;
            r_secs      <= w_secs_next;
            r_pending   <= w_pending_next;
            r_resume_ew <= w_resume_next;
            r_ped_ack   <= w_walk_entry;
            r_lamps     <= w_lamps_next;
        end
    end

    assign bus.ns_light  = r_lamps.ns;
    assign bus.ew_light  = r_lamps.ew;
    assign bus.walk      = r_lamps.walk;
    assign bus.ped_ack   = r_ped_ack;
    assign bus.secs_left = r_secs;

endmodule
